// File: rtl/ttl_sync_counter.sv
// Presettable synchronous modulo-N up/down counter in the style of the TTL '16x/'19x parts.
// Stages cascade by wiring RCO of one stage to ENT of the next on a shared CLK.
module ttl_sync_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             CLK,
   input  logic             _R,
   input  logic             _SCLR,
   input  logic             _LOAD,
   input  logic [WIDTH-1:0] D,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             UP,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   input  logic             VCC,
   input  logic             GND
);

   if (WIDTH < 1 || WIDTH > 16) begin : gen_bad_width
      $error("ttl_sync_counter: WIDTH %0d outside 1..16", WIDTH);
   end
   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : gen_bad_modulus
      $error("ttl_sync_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
   end

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] q_q, q_d;

   // Out-of-range values (loaded via D) wrap to 0 going up and decrement normally going down.
   always_comb begin
      q_d = q_q;
      if (!_SCLR) begin
         q_d = '0;
      end else if (!_LOAD) begin
         q_d = D;
      end else if (ENP && ENT) begin
         if (UP) begin
            q_d = (q_q >= MAX_Q) ? '0 : q_q + WIDTH'(1);
         end else begin
            q_d = (q_q == '0) ? MAX_Q : q_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge _R) begin
      if (!_R) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q   = q_q;
   assign RCO = ENT & (UP ? (q_q == MAX_Q) : (q_q == '0));

   // Supply pins exist only for pin compatibility.
   logic unused_supply;
   assign unused_supply = VCC ^ GND;

endmodule

// File: tb/tb_ttl_sync_counter.sv
// Scoreboard bench: a modulo-10 counter plus two cascaded modulo-16 stages.
module tb_ttl_sync_counter;

   typedef struct {
      int q;
      bit rco;
   } exp_t;

   exp_t sb10[$];
   exp_t sbc[$];
   int   checks  = 0;
   int   errors  = 0;
   int   model10 = 0;
   int   modelc  = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic vcc   = 1'b1;
   logic gnd   = 1'b0;
   logic vcc_x = 1'bx;
   logic gnd_z = 1'bz;

   logic       r_n, sclr_n, load_n, enp, ent, up;
   logic [3:0] d, q10;
   logic       rco10;

   logic       cr_n, c_sclr_n, c_load_n, c_enp, c_ent, c_up;
   logic [3:0] c_d, q_lo, q_hi;
   logic       rco_lo, rco_hi;

   ttl_sync_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
      .CLK(clk), ._R(r_n), ._SCLR(sclr_n), ._LOAD(load_n), .D(d), .ENP(enp), .ENT(ent),
      .UP(up), .Q(q10), .RCO(rco10), .VCC(vcc), .GND(gnd)
   );

   ttl_sync_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
      .CLK(clk), ._R(cr_n), ._SCLR(c_sclr_n), ._LOAD(c_load_n), .D(c_d), .ENP(c_enp),
      .ENT(c_ent), .UP(c_up), .Q(q_lo), .RCO(rco_lo), .VCC(vcc_x), .GND(gnd_z)
   );

   ttl_sync_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
      .CLK(clk), ._R(cr_n), ._SCLR(c_sclr_n), ._LOAD(c_load_n), .D(c_d), .ENP(c_enp),
      .ENT(rco_lo), .UP(c_up), .Q(q_hi), .RCO(rco_hi), .VCC(vcc_x), .GND(gnd_z)
   );

   function automatic int model_next(input int q, input int m, input logic s, input logic l,
                                     input int dv, input logic p, input logic t, input logic u);
      if (!s) return 0;
      if (!l) return dv;
      if (p && t) begin
         if (u) return (q >= m - 1) ? 0 : q + 1;
         return (q == 0) ? m - 1 : q - 1;
      end
      return q;
   endfunction

   function automatic bit model_rco(input int q, input int m, input logic t, input logic u);
      return t && (u ? (q == m - 1) : (q == 0));
   endfunction

   task automatic drive10(input logic s, input logic l, input logic [3:0] dv, input logic p,
                          input logic t, input logic u);
      exp_t e;
      @(negedge clk);
      sclr_n = s; load_n = l; d = dv; enp = p; ent = t; up = u;
      model10 = model_next(model10, 10, s, l, int'(dv), p, t, u);
      e.q     = model10;
      e.rco   = model_rco(model10, 10, t, u);
      sb10.push_back(e);
   endtask

   // The cascade behaves as one 8-bit counter; a load puts D into both nibbles.
   task automatic drivec(input logic s, input logic l, input logic [3:0] dv, input logic p,
                         input logic t, input logic u);
      exp_t e;
      @(negedge clk);
      c_sclr_n = s; c_load_n = l; c_d = dv; c_enp = p; c_ent = t; c_up = u;
      modelc = model_next(modelc, 256, s, l, int'(dv) * 17, p, t, u);
      e.q    = modelc;
      e.rco  = model_rco(modelc, 256, t, u);
      sbc.push_back(e);
   endtask

   task automatic test_reset();
      r_n = 1'b0; sclr_n = 1'b1; load_n = 1'b1; d = 4'd0; enp = 1'b1; ent = 1'b1; up = 1'b0;
      cr_n = 1'b0; c_sclr_n = 1'b1; c_load_n = 1'b1; c_d = 4'd0; c_enp = 1'b1; c_ent = 1'b0;
      c_up = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q10 !== 4'd0) begin
         errors++; $display("FAIL reset_q: Q=%0d, expected 0", q10);
      end
      checks++;
      if (rco10 !== 1'b1) begin
         errors++; $display("FAIL reset_rco_down: RCO=%b, expected 1", rco10);
      end
      up = 1'b1;
      #1;
      checks++;
      if (rco10 !== 1'b0) begin
         errors++; $display("FAIL reset_rco_up: RCO=%b, expected 0", rco10);
      end
      checks++;
      if ({q_hi, q_lo} !== 8'd0) begin
         errors++; $display("FAIL reset_cascade: Q=%0d, expected 0", {q_hi, q_lo});
      end
      ent = 1'b0;
      model10 = 0;
      modelc  = 0;
      @(negedge clk);
      r_n  = 1'b1;
      cr_n = 1'b1;
   endtask

   task automatic test_count_up();
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         drive10(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
         @(posedge clk);
         #1;
         e = sb10.pop_front();
         checks++;
         if (int'(q10) !== e.q || rco10 !== e.rco) begin
            errors++;
            $display("FAIL count_up edge %0d: Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                     i, q10, rco10, e.q, e.rco);
         end
      end
   endtask

   task automatic test_count_down();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drivec(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
         if (i == 0) begin
            #1;
            checks++;
            if (q_lo !== 4'd0 || rco_lo !== 1'b1) begin
               errors++;
               $display("FAIL down_terminal: Q=%0d RCO=%b, expected Q=0 RCO=1", q_lo, rco_lo);
            end
         end
         @(posedge clk);
         #1;
         e = sbc.pop_front();
         checks++;
         if (int'({q_hi, q_lo}) !== e.q || rco_hi !== e.rco) begin
            errors++;
            $display("FAIL count_down edge %0d: Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                     i, {q_hi, q_lo}, rco_hi, e.q, e.rco);
         end
      end
   endtask

   // Rows are {_SCLR, _LOAD, D[3:0], ENP, ENT, UP}.
   task automatic test_clear_load();
      exp_t       e;
      logic [8:0] rows[8];
      rows = '{9'b1_0_0101_0_0_1,   // load 5
               9'b0_0_1100_1_1_1,   // clear beats load -> 0
               9'b1_0_1100_0_0_1,   // load out-of-range 12
               9'b1_1_0000_1_1_1,   // up from 12 -> 0
               9'b1_0_1100_0_0_0,   // load 12
               9'b1_1_0000_1_1_0,   // down from 12 -> 11
               9'b1_0_0000_1_1_0,   // load beats count -> 0
               9'b1_1_0000_1_1_0};  // down from 0 -> 9
      for (int i = 0; i < 8; i++) begin
         drive10(rows[i][8], rows[i][7], rows[i][6:3], rows[i][2], rows[i][1], rows[i][0]);
         @(posedge clk);
         #1;
         e = sb10.pop_front();
         checks++;
         if (int'(q10) !== e.q || rco10 !== e.rco) begin
            errors++;
            $display("FAIL clear_load row %0d: Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                     i, q10, rco10, e.q, e.rco);
         end
      end
   endtask

   task automatic test_hold();
      exp_t       e;
      logic [8:0] rows[10];
      rows = '{9'b1_0_0111_1_1_1,   // load 7
               9'b1_1_0000_1_0_1, 9'b1_1_0000_1_0_1, 9'b1_1_0000_1_0_1, 9'b1_1_0000_1_0_1,
               9'b1_0_1001_0_0_1,   // load 9
               9'b1_1_0000_0_1_1,   // ENP low: hold, RCO still high
               9'b1_1_0000_0_1_0,   // direction change only
               9'b1_1_0000_1_1_0,   // 9 -> 8
               9'b1_1_0000_1_1_1};  // 8 -> 9
      for (int i = 0; i < 10; i++) begin
         drive10(rows[i][8], rows[i][7], rows[i][6:3], rows[i][2], rows[i][1], rows[i][0]);
         @(posedge clk);
         #1;
         e = sb10.pop_front();
         checks++;
         if (int'(q10) !== e.q || rco10 !== e.rco) begin
            errors++;
            $display("FAIL hold row %0d: Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                     i, q10, rco10, e.q, e.rco);
         end
      end
   endtask

   task automatic test_cascade();
      exp_t e;
      drivec(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      e = sbc.pop_front();
      checks++;
      if (int'({q_hi, q_lo}) !== e.q) begin
         errors++; $display("FAIL cascade_clear: Q=%0d, expected %0d", {q_hi, q_lo}, e.q);
      end
      for (int i = 0; i < 300; i++) begin
         drivec(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
         @(posedge clk);
         #1;
         e = sbc.pop_front();
         checks++;
         if (int'({q_hi, q_lo}) !== e.q || rco_hi !== e.rco) begin
            errors++;
            $display("FAIL cascade edge %0d: Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                     i, {q_hi, q_lo}, rco_hi, e.q, e.rco);
         end
      end
      checks++;
      if ({q_hi, q_lo} !== 8'd44) begin
         errors++; $display("FAIL cascade_300: Q=%0d, expected 44", {q_hi, q_lo});
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      drive10(1'b1, 1'b0, 4'd6, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      e = sb10.pop_front();
      checks++;
      if (int'(q10) !== e.q) begin
         errors++; $display("FAIL async_preload: Q=%0d, expected %0d", q10, e.q);
      end
      #1 r_n = 1'b0;
      #1;
      checks++;
      if (q10 !== 4'd0) begin
         errors++; $display("FAIL async_immediate: Q=%0d, expected 0", q10);
      end
      @(posedge clk);
      #1;
      checks++;
      if (q10 !== 4'd0) begin
         errors++; $display("FAIL async_held: Q=%0d, expected 0", q10);
      end
      #2 r_n = 1'b1;
      model10 = 0;
      drive10(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      e = sb10.pop_front();
      checks++;
      if (int'(q10) !== e.q) begin
         errors++; $display("FAIL async_release: Q=%0d, expected %0d", q10, e.q);
      end
      // Reset asserted in the same time step as a counting edge must still win.
      @(negedge clk);
      @(posedge clk);
      r_n = 1'b0;
      #1;
      checks++;
      if (q10 !== 4'd0) begin
         errors++; $display("FAIL async_same_edge: Q=%0d, expected 0", q10);
      end
      @(negedge clk);
      r_n = 1'b1;
      model10 = 0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 60; i++) begin
         drive10($urandom_range(0, 7) != 0, $urandom_range(0, 4) != 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
         @(posedge clk);
         #1;
         e = sb10.pop_front();
         checks++;
         if (int'(q10) !== e.q || rco10 !== e.rco) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: Q=%0d RCO=%b, expected Q=%0d RCO=%b",
                     i, q10, rco10, e.q, e.rco);
         end
      end
      checks++;
      if (sb10.size() + sbc.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb10.size() + sbc.size());
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_count_down();
      test_clear_load();
      test_hold();
      test_cascade();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
